mem_store_agu: RTL and testbench

- Store-side address generator and memory writer for CGRA dataflow kernels; the write counterpart of the load path that feeds Mem read ports from a base + stride*index address chain.
- Accepts a valid/ready result stream, e.g. a MAC accumulator output. Writes element k to address BASE_ADDR + STRIDE*k on a Mem write port for a programmed trip count, then pulses done.
- Sits between a kernel result node and the Mem write_data/write_en/addr0 inputs. It gates on the fabric-wide enable like reg_unit.

---
 rtl/mem_store_agu_if.sv | 19 +
 rtl/mem_store_agu.sv | 82 ++++++++
 tb/tb_mem_store_agu.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mem_store_agu_if.sv
// mem_store_agu_if: result stream into the store AGU and its Mem write port out
interface mem_store_agu_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] addr0;
   logic [WIDTH-1:0] write_data;
   logic             write_en;
   modport master (
      output in_data, in_valid,
      input  in_ready, addr0, write_data, write_en
   );
   modport slave (
      input  in_data, in_valid,
      output in_ready, addr0, write_data, write_en
   );
endinterface

// File: rtl/mem_store_agu.sv
// mem_store_agu: writes stream element k to BASE_ADDR + STRIDE*k for a latched trip count, then pulses done
module mem_store_agu #(
   parameter int               WIDTH       = 32,
   parameter logic [WIDTH-1:0] BASE_ADDR   = '0,
   parameter logic [WIDTH-1:0] STRIDE      = WIDTH'(4),
   parameter int               COUNT_WIDTH = 16
) (
   input  logic                   UserCLK,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic                   start,
   input  logic [COUNT_WIDTH-1:0] trip_count,
   mem_store_agu_if.slave         bus,
   output logic                   busy,
   output logic                   done
);
   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
   state_t                 state, state_n;
   logic [COUNT_WIDTH-1:0] count, count_n, index, index_n;
   logic [WIDTH-1:0]       cur_addr, cur_addr_n, addr_q, addr_n, data_q, data_n;
   logic                   wen_q, wen_n, hs, last;
   assign hs             = (state == RUN) & en & bus.in_valid;
   assign last           = index == count - 1'b1;
   assign bus.in_ready   = (state == RUN) & en;
   assign bus.write_en   = wen_q & en;
   assign bus.addr0      = addr_q;
   assign bus.write_data = data_q;
   assign busy           = state == RUN;
   assign done           = (state == FIN) & en;
   // state register; an async reset abandons any run in progress
   always_ff @(posedge UserCLK or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   // datapath registers: trip count, element index, address chain and the write port
   always_ff @(posedge UserCLK or negedge rst_n)
      if (!rst_n) begin
         count    <= '0;
         index    <= '0;
         cur_addr <= BASE_ADDR;
         addr_q   <= '0;
         data_q   <= '0;
         wen_q    <= 1'b0;
      end else begin
         count    <= count_n;
         index    <= index_n;
         cur_addr <= cur_addr_n;
         addr_q   <= addr_n;
         data_q   <= data_n;
         wen_q    <= wen_n;
      end
   // next state and datapath; with en low everything holds, including a pending write strobe
   always_comb begin
      state_n    = state;
      count_n    = count;
      index_n    = index;
      cur_addr_n = cur_addr;
      addr_n     = addr_q;
      data_n     = data_q;
      wen_n      = wen_q;
      if (en) begin
         wen_n = hs;
         if (hs) begin
            addr_n     = cur_addr;
            data_n     = bus.in_data;
            cur_addr_n = cur_addr + STRIDE;
            index_n    = last ? index : index + 1'b1;
         end
         case (state)
            IDLE:
               if (start) begin
                  count_n    = trip_count;
                  index_n    = '0;
                  cur_addr_n = BASE_ADDR;
                  state_n    = (trip_count == '0) ? FIN : RUN;
               end
            RUN:     state_n = (hs && last) ? FIN : RUN;
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_store_agu.sv
// tb_mem_store_agu: two AGUs (normal and wrapping base) checked against an element-list model
module tb_mem_store_agu;
   localparam int W = 32, CW = 16;
   localparam logic [W-1:0] BA = 32'd2560, BB = 32'hFFFF_FFF8;
   logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, start = 1'b0, in_valid = 1'b0;
   logic [CW-1:0] trip_count = '0;
   logic [W-1:0] in_data = '0;
   logic busy_a, done_a, busy_b, done_b;
   int tests = 0, fails = 0;
   logic [W-1:0] dat [16];
   logic [W-1:0] wa [16], wd [16], wba [16], wbd [16];
   int nwa, nwb, ndone, done_at, hs, bad, busy_seen;
   bit done_last_ok;
   always #5 clk = ~clk;
   mem_store_agu_if #(.WIDTH(W)) ia ();
   mem_store_agu_if #(.WIDTH(W)) ib ();
   assign ia.in_data  = in_data;
   assign ia.in_valid = in_valid;
   assign ib.in_data  = in_data;
   assign ib.in_valid = in_valid;
   mem_store_agu #(.WIDTH(W), .BASE_ADDR(BA), .STRIDE(32'd4), .COUNT_WIDTH(CW)) dut_a (
      .UserCLK(clk), .rst_n(rst_n), .en(en), .start(start), .trip_count(trip_count),
      .bus(ia), .busy(busy_a), .done(done_a));
   mem_store_agu #(.WIDTH(W), .BASE_ADDR(BB), .STRIDE(32'd4), .COUNT_WIDTH(CW)) dut_b (
      .UserCLK(clk), .rst_n(rst_n), .en(en), .start(start), .trip_count(trip_count),
      .bus(ib), .busy(busy_b), .done(done_b));
   // drives one run (inputs just after posedge, observation at negedge) and records what the DUTs did
   task automatic run(input int n, input int vmode, input int stall_at, input bit xstart, input int abort_at);
      int stalled = 0;
      bit stall_once = 0;
      nwa = 0; nwb = 0; ndone = 0; done_at = -1; hs = 0; bad = 0; busy_seen = 0; done_last_ok = 0;
      for (int k = 0; k < 16; k++) dat[k] = $urandom;
      for (int c = 0; c < 300; c++) begin
         @(posedge clk); #1;
         start = (c == 0) || (xstart && c == 3);
         trip_count = (c == 0) ? CW'(n) : CW'(9);
         if (stall_at >= 0 && !stall_once && c > 0 && hs == stall_at) begin stalled = 3; stall_once = 1; end
         en = (stalled == 0);
         if (stalled > 0) stalled--;
         in_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? (c % 2 == 0) : 1'($urandom_range(0, 1));
         in_data = dat[hs & 15];
         @(negedge clk);
         if (!en && (ia.in_ready || ia.write_en || done_a || ib.write_en)) bad++;
         if (c == 0 && ia.in_ready) bad++;
         if (ib.in_ready !== ia.in_ready || done_b !== done_a || busy_b !== busy_a) bad++;
         if (done_at >= 0 && (ia.in_ready || busy_a)) bad++;
         if (busy_a) busy_seen++;
         if (in_valid && ia.in_ready) hs++;
         if (ia.write_en) begin if (nwa < 16) begin wa[nwa] = ia.addr0; wd[nwa] = ia.write_data; end nwa++; end
         if (ib.write_en) begin if (nwb < 16) begin wba[nwb] = ib.addr0; wbd[nwb] = ib.write_data; end nwb++; end
         if (done_a) begin
            ndone++;
            if (done_at < 0) begin
               done_at = c;
               done_last_ok = (n == 0) ? !ia.write_en : (ia.write_en && nwa == n);
            end
         end
         if (abort_at >= 0 && nwa == abort_at) break;
         if (done_at >= 0 && c >= done_at + 2) break;
      end
      start = 1'b0; in_valid = 1'b0; en = 1'b1;
   endtask
   task automatic test_reset;
      en = 1'b1; start = 1'b1; trip_count = 16'd3; in_valid = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      tests++; if (ia.addr0 !== 32'd0 || ia.write_data !== 32'd0) begin fails++; $display("FAIL reset_bus addr0=%h data=%h exp 0/0", ia.addr0, ia.write_data); end
      tests++; if ({ia.write_en, ia.in_ready, busy_a, done_a} !== 4'b0) begin fails++; $display("FAIL reset_ctrl wen/rdy/busy/done=%b exp 0000", {ia.write_en, ia.in_ready, busy_a, done_a}); end
      start = 1'b0; in_valid = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      tests++; if ({ia.write_en, ia.in_ready, busy_a, done_a} !== 4'b0) begin fails++; $display("FAIL idle_after_reset got %b exp 0000", {ia.write_en, ia.in_ready, busy_a, done_a}); end
   endtask
   task automatic test_basic;
      bit ok = 1;
      run(4, 0, -1, 0, -1);
      for (int k = 0; k < 4; k++) if (wa[k] !== BA + 32'(4 * k) || wd[k] !== dat[k]) ok = 0;
      tests++; if (nwa != 4 || !ok) begin fails++; $display("FAIL basic_writes count=%0d ok=%0d exp 4/1", nwa, ok); end
      tests++; if (done_at != 5 || ndone != 1 || !done_last_ok) begin fails++; $display("FAIL basic_done at=%0d n=%0d last=%0d exp 5/1/1", done_at, ndone, done_last_ok); end
      tests++; if (bad != 0 || busy_seen != 4) begin fails++; $display("FAIL basic_ctrl bad=%0d busy=%0d exp 0/4", bad, busy_seen); end
   endtask
   task automatic test_backpressure;
      bit ok = 1;
      run(4, 1, -1, 0, -1);
      for (int k = 0; k < 4; k++) if (wa[k] !== BA + 32'(4 * k) || wd[k] !== dat[k]) ok = 0;
      tests++; if (nwa != 4 || !ok) begin fails++; $display("FAIL bp_writes count=%0d ok=%0d exp 4/1", nwa, ok); end
      tests++; if (done_at != 9 || ndone != 1 || !done_last_ok || bad != 0) begin fails++; $display("FAIL bp_done at=%0d n=%0d last=%0d bad=%0d exp 9/1/1/0", done_at, ndone, done_last_ok, bad); end
   endtask
   task automatic test_enable_stall;
      run(4, 0, 2, 0, -1);
      tests++; if (bad != 0) begin fails++; $display("FAIL stall_quiet bad=%0d exp 0", bad); end
      tests++; if (nwa != 4 || wa[2] !== 32'd2568 || wd[2] !== dat[2] || wa[1] !== 32'd2564) begin fails++; $display("FAIL stall_writes count=%0d a2=%h exp 4/%h", nwa, wa[2], 32'd2568); end
      tests++; if (done_at != 8 || ndone != 1 || !done_last_ok) begin fails++; $display("FAIL stall_done at=%0d n=%0d exp 8/1", done_at, ndone); end
   endtask
   task automatic test_zero_count;
      run(0, 0, -1, 0, -1);
      tests++; if (nwa != 0 || nwb != 0 || busy_seen != 0) begin fails++; $display("FAIL zero_quiet writes=%0d busy=%0d exp 0/0", nwa, busy_seen); end
      tests++; if (done_at != 1 || ndone != 1 || !done_last_ok || bad != 0) begin fails++; $display("FAIL zero_done at=%0d n=%0d exp 1/1", done_at, ndone); end
   endtask
   task automatic test_wrap_ignored_start;
      run(3, 0, -1, 1, -1);
      tests++; if (nwb != 3 || wba[0] !== 32'hFFFF_FFF8 || wba[1] !== 32'hFFFF_FFFC || wba[2] !== 32'h0) begin fails++; $display("FAIL wrap_addr n=%0d a=%h,%h,%h exp 3/fffffff8,fffffffc,00000000", nwb, wba[0], wba[1], wba[2]); end
      tests++; if (wbd[2] !== dat[2] || nwa != 3) begin fails++; $display("FAIL wrap_data d2=%h exp %h nwa=%0d", wbd[2], dat[2], nwa); end
      tests++; if (done_at != 4 || ndone != 1 || bad != 0) begin fails++; $display("FAIL xstart_done at=%0d n=%0d bad=%0d exp 4/1/0", done_at, ndone, bad); end
   endtask
   task automatic test_async_reset;
      int extra = 0;
      run(4, 0, -1, 0, 2);
      in_valid = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      tests++; if ({ia.write_en, busy_a, done_a, ia.in_ready} !== 4'b0 || ia.addr0 !== 32'd0 || ia.write_data !== 32'd0) begin fails++; $display("FAIL arst_outputs wen/busy/done/rdy=%b addr=%h exp 0000/0", {ia.write_en, busy_a, done_a, ia.in_ready}, ia.addr0); end
      repeat (3) begin @(negedge clk); if (ia.write_en || ib.write_en) extra++; end
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (2) begin @(negedge clk); if (ia.write_en || busy_a) extra++; end
      tests++; if (extra != 0) begin fails++; $display("FAIL arst_no_resume extra=%0d exp 0", extra); end
      run(2, 0, -1, 0, -1);
      tests++; if (nwa != 2 || wa[0] !== BA || wa[1] !== BA + 32'd4 || wd[1] !== dat[1] || ndone != 1) begin fails++; $display("FAIL arst_rerun n=%0d a0=%h a1=%h exp 2/%h/%h", nwa, wa[0], wa[1], BA, BA + 32'd4); end
   endtask
   task automatic test_random;
      for (int it = 0; it < 8; it++) begin
         int n = $urandom_range(1, 10);
         int st = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n)) : -1;
         bit ok = 1;
         run(n, 2, st, 0, -1);
         for (int k = 0; k < n; k++)
            if (wa[k] !== BA + 32'(4 * k) || wd[k] !== dat[k] || wba[k] !== BB + 32'(4 * k) || wbd[k] !== dat[k]) ok = 0;
         tests++; if (nwa != n || nwb != n || !ok) begin fails++; $display("FAIL rand%0d_writes n=%0d got %0d/%0d ok=%0d", it, n, nwa, nwb, ok); end
         tests++; if (hs != n || ndone != 1 || !done_last_ok || bad != 0) begin fails++; $display("FAIL rand%0d_ctrl hs=%0d done=%0d last=%0d bad=%0d exp %0d/1/1/0", it, hs, ndone, done_last_ok, bad, n); end
      end
   endtask
   initial begin
      test_reset;
      test_basic;
      test_backpressure;
      test_enable_stall;
      test_zero_count;
      test_wrap_ignored_start;
      test_async_reset;
      test_random;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL watchdog expired tests=%0d", tests);
      $fatal(1, "watchdog");
   end
endmodule
